run_len_detector: RTL and testbench

- Parametrised successor to the fixed 4-in-a-row one-hot sequence detector.
- Samples serial bit W and tracks the length of the current run of identical bits.
- Asserts S while the run length is at or above a runtime threshold, with per-polarity mode select.
- Adds a detection pulse and a saturating event counter. Sits after the bit-serial front end as a line-pattern or stuck-bit monitor.

---
 rtl/run_len_detector.sv | 147 ++++++++++++++
 tb/tb_run_len_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/run_len_detector.sv
// run_len_detector
// Serial run-length monitor. It tracks the polarity and the length of the
// current run of identical bits on W, which is sampled when EN is high. S is
// asserted while the run has reached a runtime threshold and its polarity is
// enabled by MODE. Each rising edge of S produces a one-cycle DET_PULSE and
// increments a saturating event counter. All outputs come from registers.

module run_len_detector #(
    parameter int MAX_RUN = 8,
    parameter int CW      = 4,
    parameter int DW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          W,
    input  logic [CW-1:0] RUN_LEN,
    input  logic [1:0]    MODE,
    input  logic          CLR_CNT,
    output logic          S,
    output logic          DET_PULSE,
    output logic          RUN_BIT,
    output logic [CW-1:0] RUN_CNT,
    output logic [DW-1:0] DET_CNT
);

    // The saturation point and the smallest legal threshold, both at counter width.
    localparam logic [CW-1:0] MAX_RUN_C = CW'(MAX_RUN);
    localparam logic [CW-1:0] MIN_THR_C = CW'(2);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [DW-1:0] DET_ONE_C = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no sample seen since reset
        ST_RUN  = 2'd1,   // run tracked, below threshold or polarity masked
        ST_HIT  = 2'd2    // run qualifies, S high
    } state_t;

    state_t          state_reg, state_next;
    logic            run_bit_reg, run_bit_next;
    logic [CW-1:0]   run_cnt_reg, run_cnt_next;
    logic            s_reg, s_next;
    logic            det_pulse_reg, det_pulse_next;
    logic [DW-1:0]   det_cnt_reg, det_cnt_next;

    logic [CW-1:0]   thr;
    logic [1:0]      pol_ok;
    logic            hit_n;

    // Clamp the runtime threshold into [2, MAX_RUN]. A threshold of 1 would
    // fire on every sample, so the low end is pinned to 2.
    always_comb begin
        thr = RUN_LEN;
        if (RUN_LEN < MIN_THR_C) begin
            thr = MIN_THR_C;
        end else if (RUN_LEN > MAX_RUN_C) begin
            thr = MAX_RUN_C;
        end
    end

    // Polarity qualification: entry gi is high when runs of value gi may
    // assert S under the current MODE (MODE[1] enables both polarities).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pol
            assign pol_ok[gi] = MODE[1] | (MODE[0] == 1'(gi));
        end
    endgenerate

    // State and datapath registers; reset wins over every other control.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            run_bit_reg   <= 1'b0;
            run_cnt_reg   <= '0;
            s_reg         <= 1'b0;
            det_pulse_reg <= 1'b0;
            det_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            run_bit_reg   <= run_bit_next;
            run_cnt_reg   <= run_cnt_next;
            s_reg         <= s_next;
            det_pulse_reg <= det_pulse_next;
            det_cnt_reg   <= det_cnt_next;
        end
    end

    // Next-state logic: run update, detect evaluation and event counting.
    always_comb begin
        state_next     = state_reg;
        run_bit_next   = run_bit_reg;
        run_cnt_next   = run_cnt_reg;
        s_next         = s_reg;
        det_pulse_next = 1'b0;
        det_cnt_next   = det_cnt_reg;
        hit_n          = 1'b0;

        if (EN) begin
            // Run update. A new run starts on the first sample after reset
            // and on every polarity change; otherwise the run grows and
            // saturates at MAX_RUN.
            case (state_reg)
                ST_RUN, ST_HIT: begin
                    if (W == run_bit_reg) begin
                        if (run_cnt_reg >= MAX_RUN_C) begin
                            run_cnt_next = MAX_RUN_C;
                        end else begin
                            run_cnt_next = run_cnt_reg + ONE_C;
                        end
                    end else begin
                        run_bit_next = W;
                        run_cnt_next = ONE_C;
                    end
                end
                default: begin
                    run_bit_next = W;
                    run_cnt_next = ONE_C;
                end
            endcase

            // Detect evaluation on the updated run, using the threshold and
            // mode present at this sample (changes are never retroactive).
            hit_n          = (run_cnt_next >= thr) && pol_ok[run_bit_next];
            s_next         = hit_n;
            state_next     = hit_n ? ST_HIT : ST_RUN;
            det_pulse_next = hit_n & ~s_reg;
        end

        // Event counter: a clear and a coincident pulse leave exactly one
        // event counted; otherwise count up and hold at all-ones.
        if (CLR_CNT) begin
            det_cnt_next = det_pulse_next ? DET_ONE_C : '0;
        end else if (det_pulse_next && (det_cnt_reg != '1)) begin
            det_cnt_next = det_cnt_reg + DET_ONE_C;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        S         = s_reg;
        DET_PULSE = det_pulse_reg;
        RUN_BIT   = run_bit_reg;
        RUN_CNT   = run_cnt_reg;
        DET_CNT   = det_cnt_reg;
    end

endmodule

// File: tb/tb_run_len_detector.sv
// Directed testbench for run_len_detector. A default instance (DW=16) and a
// narrow-counter instance (DW=2) share all stimulus.

module tb_run_len_detector;

    localparam int MAX_RUN = 8;
    localparam int CW      = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          w;
    logic [CW-1:0] run_len;
    logic [1:0]    mode;
    logic          clr_cnt;

    logic          s, det_pulse, run_bit;
    logic [CW-1:0] run_cnt;
    logic [15:0]   det_cnt;

    logic          s2, det_pulse2, run_bit2;
    logic [CW-1:0] run_cnt2;
    logic [1:0]    det_cnt2;

    int total  = 0;
    int passed = 0;

    run_len_detector #(.MAX_RUN(MAX_RUN), .CW(CW), .DW(16)) dut (
        .CLK(clk), .RST(rst), .EN(en), .W(w), .RUN_LEN(run_len), .MODE(mode),
        .CLR_CNT(clr_cnt), .S(s), .DET_PULSE(det_pulse), .RUN_BIT(run_bit),
        .RUN_CNT(run_cnt), .DET_CNT(det_cnt)
    );

    run_len_detector #(.MAX_RUN(MAX_RUN), .CW(CW), .DW(2)) dut2 (
        .CLK(clk), .RST(rst), .EN(en), .W(w), .RUN_LEN(run_len), .MODE(mode),
        .CLR_CNT(clr_cnt), .S(s2), .DET_PULSE(det_pulse2), .RUN_BIT(run_bit2),
        .RUN_CNT(run_cnt2), .DET_CNT(det_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one cycle at the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic cyc(input logic w_i, input logic en_i, input logic clr_i);
        @(negedge clk);
        w = w_i; en = en_i; clr_cnt = clr_i;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic samp(input logic w_i);
        cyc(w_i, 1'b1, 1'b0);
    endtask

    task automatic check_sp(input string tag, input logic s_e, input logic p_e);
        chk({tag, ".S"}, 32'(s), 32'(s_e));
        chk({tag, ".PULSE"}, 32'(det_pulse), 32'(p_e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; w = 1'b0; run_len = 4'd4; mode = 2'b10; clr_cnt = 1'b0;
        @(posedge clk);
        // Reset asserted with EN and CLR_CNT high: reset must win.
        @(negedge clk);
        en = 1'b1; w = 1'b1; clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0; clr_cnt = 1'b0;
        chk("rst.S", 32'(s), 0);
        chk("rst.PULSE", 32'(det_pulse), 0);
        chk("rst.RUN_BIT", 32'(run_bit), 0);
        chk("rst.RUN_CNT", 32'(run_cnt), 0);
        chk("rst.DET_CNT", 32'(det_cnt), 0);
        $display("txn reset: S=%0d RUN_CNT=%0d DET_CNT=%0d", s, run_cnt, det_cnt);

        // Test 1: thr=4, both polarities, W=0,0,0,0,0,1.
        samp(0); check_sp("t1.s1", 0, 0); chk("t1.s1.CNT", 32'(run_cnt), 1);
        samp(0); check_sp("t1.s2", 0, 0);
        samp(0); check_sp("t1.s3", 0, 0); chk("t1.s3.CNT", 32'(run_cnt), 3);
        samp(0); check_sp("t1.s4", 1, 1); chk("t1.s4.CNT", 32'(run_cnt), 4);
        samp(0); check_sp("t1.s5", 1, 0); chk("t1.s5.CNT", 32'(run_cnt), 5);
        samp(1); check_sp("t1.s6", 0, 0); chk("t1.s6.CNT", 32'(run_cnt), 1);
        chk("t1.s6.BIT", 32'(run_bit), 1);
        chk("t1.DET_CNT", 32'(det_cnt), 1);
        $display("txn t1: S=%0d RUN_CNT=%0d DET_CNT=%0d", s, run_cnt, det_cnt);

        // Test 2: W=1 x4 then 0 x4 -> two pulses.
        do_reset();
        samp(1); samp(1); samp(1); check_sp("t2.s3", 0, 0);
        samp(1); check_sp("t2.s4", 1, 1);
        samp(0); check_sp("t2.s5", 0, 0); chk("t2.s5.BIT", 32'(run_bit), 0);
        samp(0); samp(0); check_sp("t2.s7", 0, 0);
        samp(0); check_sp("t2.s8", 1, 1);
        chk("t2.DET_CNT", 32'(det_cnt), 2);
        $display("txn t2: S=%0d RUN_CNT=%0d DET_CNT=%0d", s, run_cnt, det_cnt);

        // Test 3: MODE=01 masks runs of 0.
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            samp(0);
            check_sp("t3.zero", 0, 0);
        end
        chk("t3.CNT", 32'(run_cnt), 6);
        chk("t3.BIT", 32'(run_bit), 0);
        samp(1); samp(1); samp(1); check_sp("t3.one3", 0, 0);
        samp(1); check_sp("t3.one4", 1, 1);
        $display("txn t3: S=%0d RUN_CNT=%0d RUN_BIT=%0d", s, run_cnt, run_bit);

        // Test 3b: MODE=00 masks runs of 1.
        do_reset();
        mode = 2'b00; run_len = 4'd2;
        samp(1); samp(1); check_sp("t3b.ones", 0, 0);
        samp(0); samp(0); check_sp("t3b.zeros", 1, 1);
        $display("txn t3b: S=%0d RUN_BIT=%0d", s, run_bit);

        // Test 4: RUN_LEN=15 clamps to 8; RUN_CNT saturates.
        do_reset();
        mode = 2'b10; run_len = 4'd15;
        for (int i = 1; i <= 12; i++) begin
            samp(1);
            chk($sformatf("t4.s%0d.CNT", i), 32'(run_cnt), (i < 8) ? i : 8);
            check_sp($sformatf("t4.s%0d", i), (i >= 8) ? 1'b1 : 1'b0, (i == 8) ? 1'b1 : 1'b0);
        end
        chk("t4.DET_CNT", 32'(det_cnt), 1);
        $display("txn t4: S=%0d RUN_CNT=%0d DET_CNT=%0d", s, run_cnt, det_cnt);

        // Test 4b: RUN_LEN=0 clamps to 2.
        do_reset();
        run_len = 4'd0;
        samp(0); check_sp("t4b.s1", 0, 0);
        samp(0); check_sp("t4b.s2", 1, 1);
        $display("txn t4b: S=%0d RUN_CNT=%0d", s, run_cnt);

        // Test 5: EN gating and mid-run reset.
        do_reset();
        run_len = 4'd4;
        samp(1); chk("t5.a.CNT", 32'(run_cnt), 1);
        cyc(0, 1'b0, 1'b0); chk("t5.b.CNT", 32'(run_cnt), 1); chk("t5.b.BIT", 32'(run_bit), 1);
        cyc(0, 1'b0, 1'b0); chk("t5.c.CNT", 32'(run_cnt), 1);
        samp(1); chk("t5.d.CNT", 32'(run_cnt), 2);
        samp(1); samp(1); check_sp("t5.e", 1, 1);
        cyc(0, 1'b0, 1'b0); check_sp("t5.hold", 1, 0); chk("t5.hold.CNT", 32'(run_cnt), 4);
        do_reset();
        check_sp("t5.rst", 0, 0);
        chk("t5.rst.CNT", 32'(run_cnt), 0);
        chk("t5.rst.DET_CNT", 32'(det_cnt), 0);
        samp(1); chk("t5.f.CNT", 32'(run_cnt), 1); chk("t5.f.BIT", 32'(run_bit), 1);
        $display("txn t5: RUN_CNT=%0d RUN_BIT=%0d", run_cnt, run_bit);

        // Test 6: threshold changed mid-run takes effect at the next sample.
        do_reset();
        run_len = 4'd8;
        for (int i = 0; i < 5; i++) samp(1);
        check_sp("t6.pre", 0, 0);
        run_len = 4'd3;
        samp(1); check_sp("t6.lower", 1, 1); chk("t6.lower.CNT", 32'(run_cnt), 6);
        run_len = 4'd8;
        samp(1); check_sp("t6.raise", 0, 0); chk("t6.raise.CNT", 32'(run_cnt), 7);
        $display("txn t6: S=%0d RUN_CNT=%0d", s, run_cnt);

        // Test 7: narrow counter saturation and clear coinciding with a pulse.
        do_reset();
        run_len = 4'd2; mode = 2'b10;
        samp(0); samp(0); samp(1); samp(1); samp(0); samp(0); samp(1); samp(1);
        chk("t7.DET_CNT16", 32'(det_cnt), 4);
        chk("t7.DET_CNT2", 32'(det_cnt2), 3);
        samp(0);
        cyc(0, 1'b1, 1'b1);
        chk("t7.clrpulse.PULSE", 32'(det_pulse2), 1);
        chk("t7.clrpulse.DET_CNT2", 32'(det_cnt2), 1);
        chk("t7.clrpulse.DET_CNT16", 32'(det_cnt), 1);
        cyc(0, 1'b0, 1'b1);
        chk("t7.clr.DET_CNT16", 32'(det_cnt), 0);
        chk("t7.clr.S", 32'(s), 1);
        $display("txn t7: DET_CNT=%0d DET_CNT2=%0d", det_cnt, det_cnt2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
